lc3_mem_ctrl: RTL and testbench

LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

---
 rtl/lc3_mem_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_ctrl.sv
// ============================================================================
// Module   : lc3_mem_ctrl
// Purpose  : LC-3 memory/MMIO access controller. Serves RAM words at
//            0..DEPTH-1 and a 4-word MMIO window (KBDR, KBSR, DDR, DSR) at
//            MMIO_BASE. One request per MIO_EN high phase, with a one-cycle
//            ready pulse R and an ERR flag valid alongside R.
// Options  : define LC3_MEM_PARITY_EN to store and check one even-parity bit
//            per RAM word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_mem_ctrl #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 'hFF00,
  parameter int                MMIO_WAIT = 2
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              MIO_EN,
  input  logic              RW,
  input  logic [ADDR_W-1:0] MAR_OUT,
  input  logic [DATA_W-1:0] MDR_OUT,
  input  logic [DATA_W-1:0] KBDR_IN,
  input  logic [DATA_W-1:0] KBSR_IN,
  input  logic [DATA_W-1:0] DSR_IN,
  output logic [DATA_W-1:0] OUT,
  output logic              R,
  output logic              LD_KBSR,
  output logic              LD_DDR,
  output logic              LD_DSR,
  output logic              ERR
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_A   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]        WAIT_INIT = 4'(MMIO_WAIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEM     = 3'd1,
    S_WAIT    = 3'd2,
    S_DONE    = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [1:0]          off_q;
  logic                rw_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   out_q;
  logic                r_q;
  logic                ld_kbsr_q;
  logic                ld_ddr_q;
  logic                ld_dsr_q;
  logic                err_q;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_word;
  logic                par_err;
  logic                req_mmio;
  logic                req_ram;

  // MMIO window is checked first so it wins whenever it overlaps RAM
  assign req_mmio = (MAR_OUT[ADDR_W-1:2] == MMIO_BASE[ADDR_W-1:2]);
  assign req_ram  = ({1'b0, MAR_OUT} < DEPTH_A);
  assign rd_word  = mem[idx_q];

`ifdef LC3_MEM_PARITY_EN
  logic par_mem [DEPTH];
  assign par_err = ((^rd_word) != par_mem[idx_q]);

  // Parity bit travels with every RAM write
  always_ff @(posedge i_Clk) begin
    if (state_q == S_MEM && rw_q) begin
      par_mem[idx_q] <= ^wdata_q;
    end
  end
`else
  assign par_err = 1'b0;
`endif

  // RAM storage has no reset so its contents survive i_Rst
  always_ff @(posedge i_Clk) begin
    if (state_q == S_MEM && rw_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Access sequencer with registered R/ERR/strobes/read data
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      off_q     <= 2'd0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      out_q     <= '0;
      r_q       <= 1'b0;
      ld_kbsr_q <= 1'b0;
      ld_ddr_q  <= 1'b0;
      ld_dsr_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // Pulsed outputs are high only for the single DONE cycle
      r_q       <= 1'b0;
      ld_kbsr_q <= 1'b0;
      ld_ddr_q  <= 1'b0;
      ld_dsr_q  <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (MIO_EN) begin
            idx_q   <= MAR_OUT[IDX_W-1:0];
            off_q   <= MAR_OUT[1:0];
            rw_q    <= RW;
            wdata_q <= MDR_OUT;
            if (req_mmio) begin
              cnt_q   <= WAIT_INIT;
              state_q <= S_WAIT;
            end else if (req_ram) begin
              state_q <= S_MEM;
            end else begin
              out_q   <= '0;
              err_q   <= 1'b1;
              r_q     <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_MEM: begin
          if (!rw_q) begin
            out_q <= rd_word;
            err_q <= par_err;
          end
          r_q     <= 1'b1;
          state_q <= S_DONE;
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            r_q     <= 1'b1;
            state_q <= S_DONE;
            case ({rw_q, off_q})
              3'b000: out_q <= KBDR_IN;
              3'b001: out_q <= KBSR_IN;
              3'b010: begin out_q <= '0; err_q <= 1'b1; end
              3'b011: out_q <= DSR_IN;
              3'b100: begin out_q <= '0; err_q <= 1'b1; end
              3'b101: ld_kbsr_q <= 1'b1;
              3'b110: ld_ddr_q  <= 1'b1;
              3'b111: ld_dsr_q  <= 1'b1;
            endcase
          end
        end
        S_DONE: begin
          state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!MIO_EN) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign OUT     = out_q;
  assign R       = r_q;
  assign LD_KBSR = ld_kbsr_q;
  assign LD_DDR  = ld_ddr_q;
  assign LD_DSR  = ld_dsr_q;
  assign ERR     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_lc3_mem_ctrl.sv
// ============================================================================
// Module   : tb_lc3_mem_ctrl
// Purpose  : Self-checking bench for lc3_mem_ctrl (default parameters).
//            Directed scenarios followed by random accesses compared against
//            an address-map level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lc3_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        mio_en;
  logic        rw;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic [15:0] kbdr;
  logic [15:0] kbsr;
  logic [15:0] dsr;
  logic [15:0] dout;
  logic        r;
  logic        ld_kbsr;
  logic        ld_ddr;
  logic        ld_dsr;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: RAM image of written words and the expected OUT value
  logic [15:0] mdl_mem [int];
  logic [15:0] mdl_out;

  lc3_mem_ctrl dut (
    .i_Clk   (clk),
    .i_Rst   (rst),
    .MIO_EN  (mio_en),
    .RW      (rw),
    .MAR_OUT (mar),
    .MDR_OUT (mdr),
    .KBDR_IN (kbdr),
    .KBSR_IN (kbsr),
    .DSR_IN  (dsr),
    .OUT     (dout),
    .R       (r),
    .LD_KBSR (ld_kbsr),
    .LD_DDR  (ld_ddr),
    .LD_DSR  (ld_dsr),
    .ERR     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: what one access should produce, from the address map alone
  task automatic model(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                       output int lat, output logic e, output logic [2:0] ld);
    int off;
    e  = 1'b0;
    ld = 3'b000;
    if (a >= 16'hFF00 && a <= 16'hFF03) begin
      lat = 2 + 2;
      off = int'(a - 16'hFF00);
      if (!wr) begin
        if (off == 0)      mdl_out = kbdr;
        else if (off == 1) mdl_out = kbsr;
        else if (off == 3) mdl_out = dsr;
        else begin mdl_out = 16'h0; e = 1'b1; end
      end else begin
        if (off == 0) begin mdl_out = 16'h0; e = 1'b1; end
        else ld[off-1] = 1'b1;
      end
    end else if (a < 16'd4096) begin
      lat = 2;
      if (wr) mdl_mem[int'(a)] = wd;
      else    mdl_out = mdl_mem[int'(a)];
    end else begin
      lat = 1;
      e = 1'b1;
      mdl_out = 16'h0;
    end
  endtask

  // One complete request/response handshake, with `hold` extra cycles of
  // MIO_EN held high after R
  task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                        input int hold);
    int          exp_lat;
    logic        exp_e;
    logic [2:0]  exp_ld;
    int          n;
    bit          seen;
    int          stray;
    logic        got_e;
    logic [2:0]  got_ld;
    logic [15:0] got_out;
    model(wr, a, wd, exp_lat, exp_e, exp_ld);
    mio_en = 1'b1; rw = wr; mar = a; mdr = wd;
    n = 0; seen = 0; stray = 0;
    got_e = 1'b0; got_ld = 3'b000; got_out = 16'h0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        // Address/data/direction changes after the request must be ignored
        rw = 1'($urandom); mar = 16'($urandom); mdr = 16'($urandom);
      end
      if (r) begin
        seen = 1; got_e = err; got_ld = {ld_dsr, ld_ddr, ld_kbsr}; got_out = dout;
      end else if (err || ld_kbsr || ld_ddr || ld_dsr) begin
        stray++;
      end
    end
    chk($sformatf("lat@%h", a), n, exp_lat);
    chk($sformatf("err@%h", a), got_e, exp_e);
    chk($sformatf("ld@%h", a), got_ld, exp_ld);
    chk($sformatf("out@%h", a), got_out, mdl_out);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      if (r || err || ld_kbsr || ld_ddr || ld_dsr) stray++;
    end
    mio_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      if (r || err || ld_kbsr || ld_ddr || ld_dsr) stray++;
    end
    chk($sformatf("stray@%h", a), stray, 0);
    chk($sformatf("outhold@%h", a), dout, mdl_out);
  endtask

  initial begin
    logic [15:0] a;
    logic        wr;
    int          stray;
    rst = 1'b0; mio_en = 1'b0; rw = 1'b0; mar = 16'h0; mdr = 16'h0;
    kbdr = 16'h0; kbsr = 16'h0; dsr = 16'h0;
    mdl_out = 16'h0;
    #1 rst = 1'b1;
    #1;
    chk("rst_out", dout, 16'h0);
    chk("rst_r", r, 1'b0);
    chk("rst_ld", {ld_dsr, ld_ddr, ld_kbsr}, 3'b000);
    chk("rst_err", err, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // RAM write then read back
    access(1'b1, 16'h0010, 16'h1234, 0);
    access(1'b0, 16'h0010, 16'h0000, 0);
    // KBSR read with wait states
    kbdr = 16'h00A5; kbsr = 16'h8000; dsr = 16'h4000;
    access(1'b0, 16'hFF01, 16'h0000, 0);
    // DDR write: strobe only, OUT untouched
    access(1'b1, 16'hFF02, 16'h0041, 0);
    // Out-of-range RAM read
    access(1'b0, 16'h2000, 16'h0000, 0);
    // DDR read and KBDR write are faults
    access(1'b0, 16'hFF02, 16'h0000, 0);
    access(1'b1, 16'hFF00, 16'h5555, 0);
    // Edge of RAM range
    access(1'b1, 16'd4095, 16'hBEEF, 0);
    access(1'b0, 16'd4095, 16'h0000, 0);
    access(1'b1, 16'd4096, 16'hDEAD, 0);
    access(1'b0, 16'h0010, 16'h0000, 10);
    access(1'b0, 16'h0010, 16'h0000, 0);

    // Reset during WAIT of a DSR write
    kbsr = 16'h1111;
    mio_en = 1'b1; rw = 1'b1; mar = 16'hFF03; mdr = 16'h7777;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    mdl_out = 16'h0;
    chk("midrst_r", r, 1'b0);
    chk("midrst_ld", {ld_dsr, ld_ddr, ld_kbsr}, 3'b000);
    chk("midrst_out", dout, 16'h0);
    mio_en = 1'b0;
    stray = 0;
    repeat (2) begin
      @(negedge clk);
      if (r || ld_dsr) stray++;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (r || ld_dsr) stray++;
    end
    chk("midrst_stray", stray, 0);
    access(1'b0, 16'hFF01, 16'h0000, 0);
    access(1'b0, 16'h0010, 16'h0000, 0);

    // Random traffic against the reference model
    for (int t = 0; t < 60; t++) begin
      kbdr = 16'($urandom); kbsr = 16'($urandom); dsr = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       a = 16'($urandom_range(0, 15));
        1:       a = 16'($urandom_range(0, 4095));
        2:       a = 16'hFF00 + 16'($urandom_range(0, 3));
        3:       a = 16'($urandom_range(4096, 16'hFEFF));
        4:       a = 16'hFF00 + 16'($urandom_range(0, 3));
        default: a = 16'($urandom_range(0, 15));
      endcase
      wr = 1'($urandom);
      if (!wr && a < 16'd4096 && !mdl_mem.exists(int'(a))) wr = 1'b1;
      access(wr, a, 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
